// File: rtl/score_tracker_pkg.sv
// Shared constants, state encoding and bit-count helpers for the level scoring path.
// The win/lives checker imports this package so both blocks count keys the same way.
package score_tracker_pkg;

  localparam int WIDTH     = 12;
  localparam int NUM_STEPS = 6;
  localparam int SCORE_W   = 5;
  localparam int STEP_W    = 3;
  localparam int HITS_W    = $clog2(WIDTH + 1);

  typedef logic [WIDTH-1:0]   code_t;
  typedef logic [STEP_W-1:0]  step_t;
  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [HITS_W-1:0]  hits_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

  function automatic hits_t popcount(input code_t value);
    hits_t n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + hits_t'(value[i]);
    end
    return n;
  endfunction

  // The sum is formed one bit wider so a carry out of SCORE_W means "clamp to max".
  function automatic score_t sat_add(input score_t score, input hits_t hits);
    logic [SCORE_W:0] sum;
    sum = (SCORE_W + 1)'(score) + (SCORE_W + 1)'(hits);
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/score_tracker_if.sv
// Scoring interface between the keyboard/beat timing side and the score tracker.
// master drives the beat/key stimulus and level codes; slave is the tracker itself.
interface score_tracker_if;
  import score_tracker_pkg::*;

  logic   start;
  logic   beat_tick;
  code_t  keys;
  code_t  level_code1;
  code_t  level_code2;
  code_t  level_code3;
  code_t  level_code4;
  code_t  level_code5;
  code_t  level_code6;

  code_t  current_code;
  step_t  step;
  logic   busy;
  score_t input_score;
  logic   score_valid;

  modport master (
    output start, beat_tick, keys,
    output level_code1, level_code2, level_code3,
    output level_code4, level_code5, level_code6,
    input  current_code, step, busy, input_score, score_valid
  );

  modport slave (
    input  start, beat_tick, keys,
    input  level_code1, level_code2, level_code3,
    input  level_code4, level_code5, level_code6,
    output current_code, step, busy, input_score, score_valid
  );

endinterface

// File: rtl/score_tracker_popcount12.sv
// Combinational 12-bit ones counter (popcount12); reused by the win/lives checker.
module score_tracker_popcount12
  import score_tracker_pkg::*;
(
  input  code_t value,
  output hits_t count
);

  assign count = popcount(value);

endmodule

// File: rtl/score_tracker.sv
// Plays the six level codes beat by beat, scores correctly pressed keys per beat
// and presents a saturating score with a one-cycle score_valid at level end.
module score_tracker
  import score_tracker_pkg::*;
(
  input logic            clock,
  input logic            resetn,
  score_tracker_if.slave bus
);

  state_t state_q, state_d;
  step_t  step_q, step_d;
  code_t  capture_q, capture_d;
  score_t score_q, score_d;
  code_t  current_code_q, current_code_d;

  code_t  codes [NUM_STEPS];
  code_t  code_now;
  code_t  code_next;
  code_t  hit_mask;
  hits_t  hits;

  assign codes[0] = bus.level_code1;
  assign codes[1] = bus.level_code2;
  assign codes[2] = bus.level_code3;
  assign codes[3] = bus.level_code4;
  assign codes[4] = bus.level_code5;
  assign codes[5] = bus.level_code6;

  // Keys pressed in the tick cycle itself still count towards that beat.
  assign code_now = (step_q < LAST_STEP + step_t'(1)) ? codes[step_q] : '0;
  assign hit_mask = (capture_q | bus.keys) & code_now;

  score_tracker_popcount12 u_popcount (
    .value (hit_mask),
    .count (hits)
  );

  always_comb begin
    // NOTE: every target gets a default before the case so no path infers a latch.
    state_d   = state_q;
    step_d    = step_q;
    capture_d = capture_q;
    score_d   = score_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = PLAY;
          step_d    = '0;
          capture_d = '0;
          score_d   = '0;
        end
      end
      PLAY: begin
        if (bus.beat_tick) begin
          score_d   = sat_add(score_q, hits);
          capture_d = '0;
          if (step_q == LAST_STEP) begin
            state_d = DONE;
          end else begin
            step_d = step_q + step_t'(1);
          end
        end else begin
          capture_d = capture_q | bus.keys;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // current_code is registered from the next step so it moves on the same edge as step.
  assign code_next      = (step_d < LAST_STEP + step_t'(1)) ? codes[step_d] : '0;
  assign current_code_d = (state_d == PLAY) ? code_next : '0;

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all of them update together.
    if (resetn) begin
      state_q        <= IDLE;
      step_q         <= '0;
      capture_q      <= '0;
      score_q        <= '0;
      current_code_q <= '0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      capture_q      <= capture_d;
      score_q        <= score_d;
      current_code_q <= current_code_d;
    end
  end

  assign bus.busy         = (state_q == PLAY);
  assign bus.score_valid  = (state_q == DONE);
  assign bus.step         = step_q;
  assign bus.input_score  = score_q;
  assign bus.current_code = current_code_q;

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed table, hand-written corner cases
// and a randomized run compared every cycle against a behavioural scoring model.
module tb_score_tracker;
  import score_tracker_pkg::*;

  logic clock = 1'b0;
  logic resetn;

  score_tracker_if st_if ();

  score_tracker u_dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (st_if.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase 0 idle, 1 playing, 2 result cycle.
  int          m_phase   = 0;
  int          m_beat    = 0;
  logic [11:0] m_pressed = '0;
  int          m_score   = 0;

  typedef struct {
    bit          start;
    bit          beat;
    logic [11:0] keys;
    int          exp_step;
    int          exp_score;
    bit          exp_busy;
    bit          exp_valid;
    logic [11:0] exp_code;
  } vec_t;

  vec_t vecs [9];
  int   sat_exp [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] code_in(input int i);
    case (i)
      0: return st_if.level_code1;
      1: return st_if.level_code2;
      2: return st_if.level_code3;
      3: return st_if.level_code4;
      4: return st_if.level_code5;
      5: return st_if.level_code6;
      default: return 12'h000;
    endcase
  endfunction

  task automatic set_code(input int i, input logic [11:0] c);
    case (i)
      0: st_if.level_code1 = c;
      1: st_if.level_code2 = c;
      2: st_if.level_code3 = c;
      3: st_if.level_code4 = c;
      4: st_if.level_code5 = c;
      5: st_if.level_code6 = c;
      default: ;
    endcase
  endtask

  task automatic set_all(input logic [11:0] c);
    for (int i = 0; i < 6; i++) set_code(i, c);
  endtask

  // Applies the scoring rules to the inputs present at this clock edge.
  task automatic model_edge();
    int hits;
    if (resetn) begin
      m_phase = 0; m_beat = 0; m_pressed = '0; m_score = 0;
    end else if (m_phase == 0) begin
      if (st_if.start) begin
        m_phase = 1; m_beat = 0; m_pressed = '0; m_score = 0;
      end
    end else if (m_phase == 1) begin
      if (st_if.beat_tick) begin
        hits = $countones((m_pressed | st_if.keys) & code_in(m_beat));
        m_score = (m_score + hits > 31) ? 31 : m_score + hits;
        m_pressed = '0;
        if (m_beat == 5) m_phase = 2;
        else m_beat = m_beat + 1;
      end else begin
        m_pressed = m_pressed | st_if.keys;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit bt, input logic [11:0] k);
    resetn          = rst;
    st_if.start     = st;
    st_if.beat_tick = bt;
    st_if.keys      = k;
    @(posedge clock);
    model_edge();
    #1;
    check("model_busy",  32'(st_if.busy),         32'(m_phase == 1));
    check("model_step",  32'(st_if.step),         32'(m_beat));
    check("model_score", 32'(st_if.input_score),  32'(m_score));
    check("model_valid", 32'(st_if.score_valid),  32'(m_phase == 2));
    check("model_code",  32'(st_if.current_code), (m_phase == 1) ? 32'(code_in(m_beat)) : 32'd0);
  endtask

  initial begin
    st_if.start = 1'b0; st_if.beat_tick = 1'b0; st_if.keys = '0;
    set_all(12'h000);
    resetn = 1'b1;

    // Reset state
    cycle(1, 0, 0, 12'h000);
    cycle(1, 0, 0, 12'h000);
    check("rst_busy",  32'(st_if.busy), 0);
    check("rst_step",  32'(st_if.step), 0);
    check("rst_score", 32'(st_if.input_score), 0);
    check("rst_valid", 32'(st_if.score_valid), 0);
    check("rst_code",  32'(st_if.current_code), 0);

    // Perfect play: hits 1..6, score 21, valid one cycle after the 6th tick
    set_code(0, 12'h001); set_code(1, 12'h003); set_code(2, 12'h007);
    set_code(3, 12'h00F); set_code(4, 12'h01F); set_code(5, 12'h03F);
    vecs[0] = '{1'b1, 1'b0, 12'h000, 0,  0, 1'b1, 1'b0, 12'h001};
    vecs[1] = '{1'b0, 1'b1, 12'h001, 1,  1, 1'b1, 1'b0, 12'h003};
    vecs[2] = '{1'b0, 1'b1, 12'h003, 2,  3, 1'b1, 1'b0, 12'h007};
    vecs[3] = '{1'b0, 1'b1, 12'h007, 3,  6, 1'b1, 1'b0, 12'h00F};
    vecs[4] = '{1'b0, 1'b1, 12'h00F, 4, 10, 1'b1, 1'b0, 12'h01F};
    vecs[5] = '{1'b0, 1'b1, 12'h01F, 5, 15, 1'b1, 1'b0, 12'h03F};
    vecs[6] = '{1'b0, 1'b1, 12'h03F, 5, 21, 1'b0, 1'b1, 12'h000};
    vecs[7] = '{1'b0, 1'b0, 12'h000, 5, 21, 1'b0, 1'b0, 12'h000};
    vecs[8] = '{1'b0, 1'b1, 12'h03F, 5, 21, 1'b0, 1'b0, 12'h000};
    for (int i = 0; i < 9; i++) begin
      cycle(0, vecs[i].start, vecs[i].beat, vecs[i].keys);
      check($sformatf("vec%0d_step", i),  32'(st_if.step),         32'(vecs[i].exp_step));
      check($sformatf("vec%0d_score", i), 32'(st_if.input_score),  32'(vecs[i].exp_score));
      check($sformatf("vec%0d_busy", i),  32'(st_if.busy),         32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_valid", i), 32'(st_if.score_valid),  32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_code", i),  32'(st_if.current_code), 32'(vecs[i].exp_code));
    end

    // Sticky capture within a beat: 0x010, 0x020 held, 0x080 at the tick -> 3 hits
    set_code(0, 12'h0F0); set_code(1, 12'h00F); set_code(2, 12'h00F);
    cycle(0, 1, 0, 12'h000);
    cycle(0, 0, 0, 12'h010);
    cycle(0, 0, 0, 12'h010);
    cycle(0, 0, 0, 12'h020);
    cycle(0, 0, 0, 12'h000);
    cycle(0, 0, 1, 12'h080);
    check("sticky_score", 32'(st_if.input_score), 3);
    check("sticky_step",  32'(st_if.step), 1);

    // Wrong keys score nothing
    cycle(0, 0, 1, 12'hFF0);
    check("wrong_keys_score", 32'(st_if.input_score), 3);
    check("wrong_keys_step",  32'(st_if.step), 2);

    // Start while busy is ignored
    cycle(0, 1, 0, 12'h000);
    check("busy_start_step",  32'(st_if.step), 2);
    check("busy_start_score", 32'(st_if.input_score), 3);
    check("busy_start_busy",  32'(st_if.busy), 1);

    // Reach step 3 with score 7, then reset mid-level
    cycle(0, 0, 1, 12'h00F);
    check("pre_rst_score", 32'(st_if.input_score), 7);
    check("pre_rst_step",  32'(st_if.step), 3);
    cycle(1, 0, 0, 12'h000);
    check("mid_rst_busy",  32'(st_if.busy), 0);
    check("mid_rst_step",  32'(st_if.step), 0);
    check("mid_rst_score", 32'(st_if.input_score), 0);
    check("mid_rst_code",  32'(st_if.current_code), 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, i[0], 12'hFFF);
      check("no_valid_after_rst", 32'(st_if.score_valid), 0);
    end

    // Start together with beat_tick in IDLE: tick not scored; then saturation
    set_all(12'hFFF);
    cycle(0, 1, 1, 12'hFFF);
    check("start_tick_step",  32'(st_if.step), 0);
    check("start_tick_score", 32'(st_if.input_score), 0);
    check("start_tick_busy",  32'(st_if.busy), 1);
    sat_exp = '{12, 24, 31, 31, 31, 31};
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 1, 12'hFFF);
      check($sformatf("sat_score%0d", i), 32'(st_if.input_score), 32'(sat_exp[i]));
    end
    check("sat_valid", 32'(st_if.score_valid), 1);

    // Start during the result cycle is ignored; outputs hold until the next start
    cycle(0, 1, 0, 12'h000);
    check("done_start_busy",  32'(st_if.busy), 0);
    check("done_start_score", 32'(st_if.input_score), 31);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 12'h000);
      check("hold_score", 32'(st_if.input_score), 31);
      check("hold_step",  32'(st_if.step), 5);
    end
    cycle(0, 1, 0, 12'h000);
    check("b2b_score", 32'(st_if.input_score), 0);
    check("b2b_step",  32'(st_if.step), 0);
    check("b2b_busy",  32'(st_if.busy), 1);

    // Randomized run with codes changing underneath the player
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) set_code(int'($urandom_range(5)), 12'($urandom_range(4095)));
      cycle($urandom_range(199) == 0, $urandom_range(11) == 0, $urandom_range(3) == 0,
            12'($urandom_range(4095) & $urandom_range(4095)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
